matrix_transpose_pingpong: RTL and testbench
============================================

Name: matrix_transpose_pingpong

Overview:
Streaming NUM_PE x NUM_PE matrix transpose unit with two ping-pong buffers. One matrix is written row-by-row while the previously completed matrix is read out column-by-column, so rows stream at one per cycle with no stall in steady state. Both sides use valid/ready handshakes. A per-matrix bypass mode emits rows unchanged. Sits between PE array stages where the NTT/transform dataflow changes from row-major to column-major.

Parameters:
DATA_WIDTH, 64, bits per matrix element
NUM_PE, 8, lanes per row and matrix dimension; power of two, >= 2
ADDR_WIDTH, $clog2(NUM_PE), row/column index width (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-low reset
in_val  input  1  input_row valid
in_rdy  output  1  unit accepts input_row this cycle
in_bypass  input  1  mode for matrix being written; sampled on its first row beat; 1 = no transpose
input_row  input  DATA_WIDTH x NUM_PE  one matrix row, lane j = column j
out_val  output  1  output_row valid
out_rdy  input  1  downstream accepts output_row
output_row  output  DATA_WIDTH x NUM_PE  one output line, lane j = row j of column k (transpose) or column j of row k (bypass)
out_last  output  1  high with the final line (k = NUM_PE-1) of a matrix
busy  output  1  any buffer full or partially written

Behaviour:
- State: buffers buf[0..1] (NUM_PE x NUM_PE x DATA_WIDTH), full[1:0], mode[1:0], wr_sel, wr_row, rd_sel, rd_col. Storage is not reset.
- Reset (rst=0, asynchronous): full=0, wr_sel=rd_sel=0, wr_row=rd_col=0, mode=0; so out_val=0, out_last=0, busy=0, in_rdy=1 the cycle after rst deasserts. Reset mid-matrix discards all partial and full matrices.
- Write: in_rdy = !full[wr_sel]. Beat accepted when in_val && in_rdy: buf[wr_sel][wr_row][*] <= input_row; on wr_row==0 latch mode[wr_sel] <= in_bypass. wr_row increments; at NUM_PE-1 wraps to 0, full[wr_sel] <= 1, wr_sel toggles.
- Read: out_val = full[rd_sel]. Transpose: output_row[j] = buf[rd_sel][j][rd_col]. Bypass: output_row[j] = buf[rd_sel][rd_col][j]. out_last = out_val && rd_col==NUM_PE-1. Output is combinational from storage (no extra register).
- Read beat on out_val && out_rdy: rd_col increments; at NUM_PE-1 wraps, full[rd_sel] <= 0, rd_sel toggles.
- Latency: first line of a matrix valid the cycle after its last row is accepted (NUM_PE+1 cycles from first input beat with continuous in_val).
- Simultaneous final write into one buffer and final read of the other: both take effect same edge; next cycle out_val=1 for the new matrix, in_rdy=1 for the freed buffer; no bubble.
- Both buffers full: in_rdy=0 until the first read line of the oldest matrix completes its last column.
- out_rdy low holds output_row/out_val/out_last stable (AXI-style: out_val never drops without handshake).
- in_val low mid-matrix: wr_row holds; gaps allowed anywhere.
- busy = |full || wr_row!=0.
- Matrices are emitted strictly in acceptance order; mode follows its matrix.

Decomposition:
- Package matrix_transpose_pkg: row_t typedef (array of NUM_PE DATA_WIDTH words), IDX_W function ($clog2), BUF_CNT=2 constant.
- Sub-module transpose_buffer: one NUM_PE x NUM_PE register array with row write port and combinational row/column read selected by mode; instantiated twice. Control counters live in the top.

Test Plan:
- NUM_PE=4, DATA_WIDTH=16, element (r,c)=16'h00RC, continuous in_val, out_rdy=1 -> out_val first at cycle 5 after first beat; lines {00,10,20,30},{01,11,21,31},...; out_last on 4th line.
- Three back-to-back matrices (base 0x000, 0x100, 0x200), out_rdy=1 -> 12 output lines, no gap between matrices, in_rdy never low.
- out_rdy=0 held for 10 cycles while 3 matrices offered -> in_rdy drops after 8 accepted rows; output line {00,10,20,30} stable; releasing out_rdy resumes in order with no loss.
- in_bypass=1 on matrix A, 0 on matrix B -> A emits {00,01,02,03} first; B emits transposed columns.
- Random in_val/out_rdy gaps, 200 matrices vs reference model -> exact match, out_last once per 4 lines.
- Assert rst low after 2 rows of matrix and with one full buffer -> next cycle out_val=0, busy=0, in_rdy=1; subsequent matrix emits correctly with no stale data.

Source files
------------

// File: rtl/matrix_transpose_pkg.sv
// Shared types and helpers for the ping-pong matrix transpose unit.
// row_t captures the default row shape; parameterised modules build their own packed rows.
package matrix_transpose_pkg;

    localparam int BUF_CNT        = 2;
    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_NUM_PE     = 8;

    // Index width for an n-entry dimension, never narrower than one bit.
    function automatic int IDX_W(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef logic [DEF_NUM_PE-1:0][DEF_DATA_WIDTH-1:0] row_t;

endpackage

// File: rtl/transpose_buffer.sv
// One NUM_PE x NUM_PE element store: row-wide write port, combinational read of a column
// (transpose) or a row (bypass); read data follows the index with zero latency.
module transpose_buffer
    import matrix_transpose_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_PE     = 8,
    localparam int ADDR_WIDTH = IDX_W(NUM_PE)
) (
    input  logic                               clk,
    input  logic                               wr_en_i,
    input  logic [ADDR_WIDTH-1:0]              wr_row_i,
    input  logic [NUM_PE-1:0][DATA_WIDTH-1:0]  wr_dat_i,
    input  logic [ADDR_WIDTH-1:0]              rd_idx_i,
    input  logic                               bypass_i,
    output logic [NUM_PE-1:0][DATA_WIDTH-1:0]  rd_dat_o
);

    // Storage is intentionally left unreset; validity is tracked by the controller.
    logic [NUM_PE-1:0][NUM_PE-1:0][DATA_WIDTH-1:0] mem_q;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_row_i] <= wr_dat_i;
        end
    end

    always_comb begin
        rd_dat_o = '0;
        for (int j = 0; j < NUM_PE; j++) begin
            if (bypass_i) begin
                rd_dat_o[j] = mem_q[rd_idx_i][j];
            end else begin
                rd_dat_o[j] = mem_q[j][rd_idx_i];
            end
        end
    end

endmodule

// File: rtl/matrix_transpose_pingpong.sv
// Streaming ping-pong transpose: first output line one cycle after a matrix's last row is accepted.
// in_rdy drops only when both buffers hold unread matrices; out_val holds until out_rdy.
module matrix_transpose_pingpong
    import matrix_transpose_pkg::*;
#(
    parameter  int DATA_WIDTH = 64,
    parameter  int NUM_PE     = 8,
    localparam int ADDR_WIDTH = IDX_W(NUM_PE)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               in_val,
    output logic                               in_rdy,
    input  logic                               in_bypass,
    input  logic [NUM_PE-1:0][DATA_WIDTH-1:0]  input_row,
    output logic                               out_val,
    input  logic                               out_rdy,
    output logic [NUM_PE-1:0][DATA_WIDTH-1:0]  output_row,
    output logic                               out_last,
    output logic                               busy
);

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_PE - 1);
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX  = ADDR_WIDTH'(1);

    logic [BUF_CNT-1:0]    full_q,   full_d;
    logic [BUF_CNT-1:0]    mode_q,   mode_d;
    logic                  wr_sel_q, wr_sel_d;
    logic                  rd_sel_q, rd_sel_d;
    logic [ADDR_WIDTH-1:0] wr_row_q, wr_row_d;
    logic [ADDR_WIDTH-1:0] rd_col_q, rd_col_d;

    logic wr_fire;
    logic rd_fire;

    logic [NUM_PE-1:0][DATA_WIDTH-1:0] buf_rd_dat [BUF_CNT];

    assign in_rdy   = !full_q[wr_sel_q];
    assign out_val  = full_q[rd_sel_q];
    assign wr_fire  = in_val && in_rdy;
    assign rd_fire  = out_val && out_rdy;

    assign output_row = buf_rd_dat[rd_sel_q];
    assign out_last   = out_val && (rd_col_q == LAST_IDX);
    assign busy       = (|full_q) || (wr_row_q != '0);

    for (genvar b = 0; b < BUF_CNT; b++) begin : g_buf
        transpose_buffer #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_PE     (NUM_PE)
        ) u_buf (
            .clk      (clk),
            .wr_en_i  (wr_fire && (wr_sel_q == 1'(b))),
            .wr_row_i (wr_row_q),
            .wr_dat_i (input_row),
            .rd_idx_i (rd_col_q),
            .bypass_i (mode_q[b]),
            .rd_dat_o (buf_rd_dat[b])
        );
    end

    // Write and read always target different buffers (one is empty, the other full),
    // so a final write and a final read in the same cycle never collide on full_d.
    always_comb begin
        full_d   = full_q;
        mode_d   = mode_q;
        wr_sel_d = wr_sel_q;
        wr_row_d = wr_row_q;
        rd_sel_d = rd_sel_q;
        rd_col_d = rd_col_q;

        if (wr_fire) begin
            if (wr_row_q == '0) begin
                mode_d[wr_sel_q] = in_bypass;
            end
            if (wr_row_q == LAST_IDX) begin
                wr_row_d         = '0;
                full_d[wr_sel_q] = 1'b1;
                wr_sel_d         = ~wr_sel_q;
            end else begin
                wr_row_d = wr_row_q + ONE_IDX;
            end
        end

        if (rd_fire) begin
            if (rd_col_q == LAST_IDX) begin
                rd_col_d         = '0;
                full_d[rd_sel_q] = 1'b0;
                rd_sel_d         = ~rd_sel_q;
            end else begin
                rd_col_d = rd_col_q + ONE_IDX;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            full_q   <= '0;
            mode_q   <= '0;
            wr_sel_q <= 1'b0;
            rd_sel_q <= 1'b0;
            wr_row_q <= '0;
            rd_col_q <= '0;
        end else begin
            full_q   <= full_d;
            mode_q   <= mode_d;
            wr_sel_q <= wr_sel_d;
            rd_sel_q <= rd_sel_d;
            wr_row_q <= wr_row_d;
            rd_col_q <= rd_col_d;
        end
    end

endmodule

// File: tb/tb_matrix_transpose_pingpong.sv
// Directed table plus scoreboard-checked sequences for the 4x4, 16-bit configuration.
module tb_matrix_transpose_pingpong;

    localparam int DW = 16;
    localparam int NP = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_val;
    logic                 in_rdy;
    logic                 in_bypass;
    logic [NP-1:0][DW-1:0] input_row;
    logic                 out_val;
    logic                 out_rdy;
    logic [NP-1:0][DW-1:0] output_row;
    logic                 out_last;
    logic                 busy;

    always #5 clk = ~clk;

    matrix_transpose_pingpong #(
        .DATA_WIDTH (DW),
        .NUM_PE     (NP)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_val     (in_val),
        .in_rdy     (in_rdy),
        .in_bypass  (in_bypass),
        .input_row  (input_row),
        .out_val    (out_val),
        .out_rdy    (out_rdy),
        .output_row (output_row),
        .out_last   (out_last),
        .busy       (busy)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] elem(input logic [15:0] base, input int r, input int c);
        return base | 16'(r * 16) | 16'(c);
    endfunction

    function automatic logic [63:0] mk_row(input logic [15:0] base, input int r);
        logic [63:0] v;
        v = '0;
        for (int j = 0; j < NP; j++) v[j*DW +: DW] = elem(base, r, j);
        return v;
    endfunction

    typedef struct {
        logic [63:0] dat;
        logic        byp;
    } beat_t;

    typedef struct {
        logic [63:0] dat;
        logic        last;
    } line_t;

    typedef struct {
        logic        in_val;
        int          row;
        logic        out_rdy;
        logic        exp_rdy;
        logic        exp_val;
        logic        exp_last;
        logic        exp_busy;
        logic [63:0] exp_line;
    } tvec_t;

    beat_t in_q[$];
    line_t exp_q[$];
    logic [63:0] part [NP];
    int   part_cnt = 0;
    logic part_byp = 1'b0;

    bit in_gate    = 1'b0;
    bit out_gate   = 1'b0;
    bit rnd        = 1'b0;
    bit chk_rdy_hi = 1'b0;
    int cyc        = 0;
    int acc_cnt    = 0;
    int out_cnt    = 0;
    int first_out  = -1;
    int last_out   = -1;

    task automatic add_matrix(input logic [15:0] base, input logic byp, input bit rand_dat);
        beat_t b;
        for (int r = 0; r < NP; r++) begin
            b.dat = rand_dat ? {$urandom(), $urandom()} : mk_row(base, r);
            // Later beats carry the opposite mode: only the first beat may count.
            b.byp = (r == 0) ? byp : ~byp;
            in_q.push_back(b);
        end
    endtask

    task automatic cycle();
        beat_t b;
        line_t e;
        logic [63:0] ln;
        in_val = in_gate && (in_q.size() > 0) && (!rnd || ($urandom_range(0, 2) != 0));
        if (in_q.size() > 0) begin
            input_row = in_q[0].dat;
            in_bypass = in_q[0].byp;
        end else begin
            input_row = '0;
            in_bypass = 1'b0;
        end
        out_rdy = out_gate && (!rnd || ($urandom_range(0, 3) != 0));
        @(negedge clk);
        if (chk_rdy_hi && in_val) chk("in_rdy_high", 64'(in_rdy), 64'd1);
        if (out_val && out_rdy) begin
            out_cnt++;
            if (first_out < 0) first_out = cyc;
            last_out = cyc;
            if (exp_q.size() == 0) begin
                chk("unexpected_line", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                chk("line_dat", output_row, e.dat);
                chk("line_last", 64'(out_last), 64'(e.last));
            end
        end
        if (in_val && in_rdy) begin
            acc_cnt++;
            b = in_q.pop_front();
            if (part_cnt == 0) part_byp = b.byp;
            part[part_cnt] = b.dat;
            part_cnt++;
            if (part_cnt == NP) begin
                for (int k = 0; k < NP; k++) begin
                    for (int j = 0; j < NP; j++) begin
                        ln[j*DW +: DW] = part_byp ? part[k][j*DW +: DW] : part[j][k*DW +: DW];
                    end
                    e.dat  = ln;
                    e.last = (k == NP - 1);
                    exp_q.push_back(e);
                end
                part_cnt = 0;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while ((in_q.size() > 0 || exp_q.size() > 0) && n < max_cyc) begin
            cycle();
            n++;
        end
        chk({name, "_drained"}, 64'(in_q.size() + exp_q.size()), 64'd0);
    endtask

    task automatic pulse_reset();
        in_val  = 1'b0;
        out_rdy = 1'b0;
        rst     = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_q.delete();
        exp_q.delete();
        part_cnt = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        tvec_t tv [9];
        int a0;
        int lines0;
        int n;

        tv[0] = '{1'b1, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};
        tv[1] = '{1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0};
        tv[2] = '{1'b1, 2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0};
        tv[3] = '{1'b1, 3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 64'h0};
        tv[4] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0030_0020_0010_0000};
        tv[5] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0031_0021_0011_0001};
        tv[6] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 64'h0032_0022_0012_0002};
        tv[7] = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 64'h0033_0023_0013_0003};
        tv[8] = '{1'b0, 0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 64'h0};

        rst       = 1'b0;
        in_val    = 1'b0;
        in_bypass = 1'b0;
        input_row = '0;
        out_rdy   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;

        // Single transposed matrix, checked cycle by cycle.
        for (int i = 0; i < 9; i++) begin
            in_val    = tv[i].in_val;
            input_row = mk_row(16'h0000, tv[i].row);
            in_bypass = 1'b0;
            out_rdy   = tv[i].out_rdy;
            @(negedge clk);
            chk($sformatf("tv%0d_in_rdy", i), 64'(in_rdy), 64'(tv[i].exp_rdy));
            chk($sformatf("tv%0d_out_val", i), 64'(out_val), 64'(tv[i].exp_val));
            chk($sformatf("tv%0d_out_last", i), 64'(out_last), 64'(tv[i].exp_last));
            chk($sformatf("tv%0d_busy", i), 64'(busy), 64'(tv[i].exp_busy));
            if (tv[i].exp_val) chk($sformatf("tv%0d_line", i), output_row, tv[i].exp_line);
            @(posedge clk);
            #1;
        end

        // Three back-to-back matrices: no input stall, no output gap.
        in_gate = 1'b1;
        out_gate = 1'b1;
        chk_rdy_hi = 1'b1;
        out_cnt = 0;
        first_out = -1;
        add_matrix(16'h0000, 1'b0, 1'b0);
        add_matrix(16'h0100, 1'b0, 1'b0);
        add_matrix(16'h0200, 1'b0, 1'b0);
        drain("seqA", 100);
        chk_rdy_hi = 1'b0;
        chk("seqA_lines", 64'(out_cnt), 64'd12);
        chk("seqA_span", 64'(last_out - first_out), 64'd11);

        // Output stalled: both buffers fill, in_rdy drops, head line holds.
        add_matrix(16'h0500, 1'b0, 1'b0);
        add_matrix(16'h0600, 1'b0, 1'b0);
        add_matrix(16'h0700, 1'b0, 1'b0);
        out_gate = 1'b0;
        a0 = acc_cnt;
        repeat (10) begin
            cycle();
            if (out_val) chk("seqB_stable", output_row, 64'h0530_0520_0510_0500);
        end
        chk("seqB_accepted", 64'(acc_cnt - a0), 64'd8);
        chk("seqB_in_rdy", 64'(in_rdy), 64'd0);
        chk("seqB_out_val", 64'(out_val), 64'd1);
        chk("seqB_busy", 64'(busy), 64'd1);
        out_gate = 1'b1;
        drain("seqB", 100);

        // Bypass matrix followed by a transposed one.
        add_matrix(16'h0300, 1'b1, 1'b0);
        add_matrix(16'h0400, 1'b0, 1'b0);
        out_gate = 1'b0;
        n = 0;
        while (!out_val && n < 20) begin
            cycle();
            n++;
        end
        chk("byp_first_line", output_row, 64'h0303_0302_0301_0300);
        out_gate = 1'b1;
        drain("seqC", 100);

        // Random handshake gaps over many random matrices.
        rnd = 1'b1;
        lines0 = out_cnt;
        for (int m = 0; m < 200; m++) add_matrix(16'h0000, 1'($urandom_range(0, 1)), 1'b1);
        drain("rand", 20000);
        chk("rand_lines", 64'(out_cnt - lines0), 64'd800);
        rnd = 1'b0;

        // Reset after two rows of a matrix.
        add_matrix(16'h0800, 1'b0, 1'b0);
        a0 = acc_cnt;
        n = 0;
        while (acc_cnt - a0 < 2 && n < 20) begin
            cycle();
            n++;
        end
        chk("rst1_busy_before", 64'(busy), 64'd1);
        pulse_reset();
        chk("rst1_out_val", 64'(out_val), 64'd0);
        chk("rst1_busy", 64'(busy), 64'd0);
        chk("rst1_in_rdy", 64'(in_rdy), 64'd1);

        // Reset with one full buffer and a partially written one.
        add_matrix(16'h0900, 1'b0, 1'b0);
        add_matrix(16'h0A00, 1'b0, 1'b0);
        out_gate = 1'b0;
        a0 = acc_cnt;
        n = 0;
        while (acc_cnt - a0 < 5 && n < 20) begin
            cycle();
            n++;
        end
        chk("rst2_out_val_before", 64'(out_val), 64'd1);
        pulse_reset();
        chk("rst2_out_val", 64'(out_val), 64'd0);
        chk("rst2_busy", 64'(busy), 64'd0);
        chk("rst2_in_rdy", 64'(in_rdy), 64'd1);

        // Fresh matrix after reset must not be mixed with stale data.
        out_gate = 1'b1;
        add_matrix(16'h0B00, 1'b0, 1'b0);
        add_matrix(16'h0C00, 1'b1, 1'b0);
        drain("post_rst", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
